// File: rtl/booth_control.sv
// Control FSM for a radix-2 Booth signed multiplier: sequences load, N add/sub-then-shift
// iterations, and a completion pulse. Issues strobes only; the datapath does the arithmetic.
module booth_control #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          start,
    input  logic          q0,
    input  logic          q_m1,
    output logic          load_en,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic          result_valid,
    output logic [CW-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OP,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CW-1:0] ITER_LAST = CW'(N - 1);
    localparam logic [CW-1:0] ITER_FULL = CW'(N);

    state_t state, next_state;
    logic   start_d;
    logic   start_rise;

    assign start_rise = start & ~start_d;
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            start_d      <= 1'b0;
            iter         <= '0;
            result_valid <= 1'b0;
        end else begin
            state   <= next_state;
            start_d <= start;
            case (state)
                LOAD: begin
                    iter         <= '0;
                    result_valid <= 1'b0;
                end
                SHIFT: begin
                    // Saturate so iter holds N through DONE/IDLE instead of wrapping
                    if (iter != ITER_FULL) iter <= iter + CW'(1);
                end
                DONE:    result_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        add_en     = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start_rise) next_state = LOAD;
            LOAD: begin
                load_en    = 1'b1;
                next_state = OP;
            end
            OP: begin
                add_en     = ~q0 & q_m1;
                sub_en     = q0 & ~q_m1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_en   = 1'b1;
                next_state = (iter == ITER_LAST) ? DONE : OP;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
